// File: rtl/wb_drp_pkg.sv
// Shared types and constants for the Wishbone-to-DRP bridge.
package wb_drp_pkg;

    localparam int DRP_DATA_WIDTH         = 16;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // A single-cycle timeout still needs one counter bit.
    function automatic int tmo_cnt_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/wb_drp_bridge_if.sv
// Wishbone slave + DRP master signal bundle; slave = bridge view, master = environment view.
interface wb_drp_bridge_if #(
    parameter int ADDR_WIDTH = 16
);
    import wb_drp_pkg::*;

    logic [ADDR_WIDTH-1:0]     wb_adr_i;
    logic [DRP_DATA_WIDTH-1:0] wb_dat_i;
    logic [DRP_DATA_WIDTH-1:0] wb_dat_o;
    logic                      wb_we_i;
    logic                      wb_stb_i;
    logic                      wb_cyc_i;
    logic                      wb_ack_o;
    logic                      wb_err_o;
    logic [ADDR_WIDTH-1:0]     drp_addr;
    logic [DRP_DATA_WIDTH-1:0] drp_do;
    logic [DRP_DATA_WIDTH-1:0] drp_di;
    logic                      drp_en;
    logic                      drp_we;
    logic                      drp_rdy;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i, drp_di, drp_rdy,
        output wb_dat_o, wb_ack_o, wb_err_o, drp_addr, drp_do, drp_en, drp_we
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i, drp_di, drp_rdy,
        input  wb_dat_o, wb_ack_o, wb_err_o, drp_addr, drp_do, drp_en, drp_we
    );

endinterface

// File: rtl/wb_drp_watchdog.sv
// DRP wait counter: cleared on WAIT entry, counts stalled cycles, flags the last allowed one.
module wb_drp_watchdog
    import wb_drp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = tmo_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CW{1'b0}};
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/wb_drp_bridge.sv
// Wishbone classic slave turning each strobe into one DRP transaction.
// Optional DRP timeout (wb_err_o) is enabled with `define WB_DRP_TIMEOUT_EN.
module wb_drp_bridge
    import wb_drp_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic            clk,
    input  logic            rst_n,
    wb_drp_bridge_if.slave  bus
);

    state_e                    state_q, state_d;
    logic                      en_q, en_d;
    logic                      we_q, we_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DRP_DATA_WIDTH-1:0] do_q, do_d;
    logic [DRP_DATA_WIDTH-1:0] dat_q, dat_d;
    logic                      ack_q, ack_d;
    logic                      err_q, err_d;
    logic                      start_s;

    // Ignoring the strobe while ack/err is visible stops a second access in the handshake cycle.
    assign start_s = bus.wb_cyc_i & bus.wb_stb_i & ~ack_q & ~err_q;

`ifdef WB_DRP_TIMEOUT_EN
    logic tmo_expired_s;
    logic wd_clr_s;
    logic wd_en_s;

    assign wd_clr_s = (state_q == IDLE) & start_s;
    assign wd_en_s  = (state_q == WAIT) & ~bus.drp_rdy;

    wb_drp_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (wd_clr_s),
        .en_i      (wd_en_s),
        .expired_o (tmo_expired_s)
    );
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        en_d    = 1'b0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        do_d    = do_q;
        dat_d   = dat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    en_d    = 1'b1;
                    we_d    = bus.wb_we_i;
                    addr_d  = bus.wb_adr_i;
                    do_d    = bus.wb_dat_i;
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                // The DRP access cannot be aborted; a dropped cycle only suppresses ack.
                if (bus.drp_rdy) begin
                    dat_d   = bus.drp_di;
                    ack_d   = bus.wb_cyc_i;
                    state_d = IDLE;
                end
`ifdef WB_DRP_TIMEOUT_EN
                else if (tmo_expired_s) begin
                    dat_d   = {DRP_DATA_WIDTH{1'b0}};
                    err_d   = bus.wb_cyc_i;
                    state_d = IDLE;
                end
`endif
                else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= {ADDR_WIDTH{1'b0}};
            do_q    <= {DRP_DATA_WIDTH{1'b0}};
            dat_q   <= {DRP_DATA_WIDTH{1'b0}};
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            do_q    <= do_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign bus.drp_en   = en_q;
    assign bus.drp_we   = we_q;
    assign bus.drp_addr = addr_q;
    assign bus.drp_do   = do_q;
    assign bus.wb_dat_o = dat_q;
    assign bus.wb_ack_o = ack_q;
    assign bus.wb_err_o = err_q;

endmodule

// File: tb/tb_wb_drp_bridge.sv
// Self-checking bench for wb_drp_bridge: directed table, multi-cycle corner sequences, random traffic.
module tb_wb_drp_bridge;
    import wb_drp_pkg::*;

    localparam int AW = 16;
`ifdef WB_DRP_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_drp_bridge_if #(.ADDR_WIDTH(AW)) bus ();

    wb_drp_bridge #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] adr;
        logic [15:0] dat;
        logic        we;
        int          dly;      // cycles from drp_en to drp_rdy
        logic [15:0] rdi;
        bit          drop;     // master drops cyc right after drp_en
        logic        exp_we;
        logic        exp_ack;
        logic [15:0] exp_dat;
    } vec_t;

    int n_vec    = 0;
    int n_bad    = 0;
    int en_seen  = 0;
    int ack_seen = 0;
    int en_exp   = 0;
    int ack_exp  = 0;
    logic [15:0] model_dat = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: one access, ack iff cyc survives, read data returned on every access.
    function automatic vec_t mk_vec(input logic [15:0] adr, input logic [15:0] dat, input logic we,
                                    input int dly, input logic [15:0] rdi, input bit drop);
        vec_t v;
        v.adr = adr; v.dat = dat; v.we = we; v.dly = dly; v.rdi = rdi; v.drop = drop;
        v.exp_we  = we;
        v.exp_ack = !drop;
        v.exp_dat = rdi;
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.drp_en)   en_seen++;
            if (bus.wb_ack_o) ack_seen++;
            chk("drp_we_without_en", {31'd0, bus.drp_we & ~bus.drp_en}, 32'd0);
`ifndef WB_DRP_TIMEOUT_EN
            chk("err_tied_low", {31'd0, bus.wb_err_o}, 32'd0);
`endif
        end
    end

    // Called at a negedge. en_wait = negedges expected after the first before drp_en shows.
    task automatic run_txn(input vec_t v, input int en_wait, input bit keep);
        int w;
        bus.wb_adr_i = v.adr;
        bus.wb_dat_i = v.dat;
        bus.wb_we_i  = v.we;
        bus.wb_stb_i = 1'b1;
        bus.wb_cyc_i = 1'b1;
        w = 0;
        @(negedge clk);
        while (!bus.drp_en && w < 20) begin
            w++;
            @(negedge clk);
        end
        chk("en_latency", w, en_wait);
        if (!bus.drp_en) begin
            bus.wb_stb_i = 1'b0;
            bus.wb_cyc_i = 1'b0;
            return;
        end
        en_exp++;
        chk("drp_addr", {16'd0, bus.drp_addr}, {16'd0, v.adr});
        chk("drp_do",   {16'd0, bus.drp_do},   {16'd0, v.dat});
        chk("drp_we",   {31'd0, bus.drp_we},   {31'd0, v.exp_we});
        // Changing address/data during WAIT must not disturb the latched DRP request.
        bus.wb_adr_i = ~v.adr;
        bus.wb_dat_i = ~v.dat;
        if (v.drop) begin
            bus.wb_cyc_i = 1'b0;
            bus.wb_stb_i = 1'b0;
        end
        for (int d = 0; d < v.dly; d++) begin
            @(negedge clk);
            if (d < 8) begin
                chk("en_one_pulse", {31'd0, bus.drp_en},   32'd0);
                chk("ack_early",    {31'd0, bus.wb_ack_o}, 32'd0);
            end
        end
        bus.drp_rdy = 1'b1;
        bus.drp_di  = v.rdi;
        @(negedge clk);
        bus.drp_rdy = 1'b0;
        bus.drp_di  = $urandom_range(0, 65535);
        chk("ack",       {31'd0, bus.wb_ack_o}, {31'd0, v.exp_ack});
        chk("dat_o",     {16'd0, bus.wb_dat_o}, {16'd0, v.exp_dat});
        chk("addr_hold", {16'd0, bus.drp_addr}, {16'd0, v.adr});
        if (v.exp_ack) ack_exp++;
        model_dat = v.exp_dat;
        if (!keep) begin
            bus.wb_stb_i = 1'b0;
            bus.wb_cyc_i = 1'b0;
            @(negedge clk);
            chk("ack_one_cycle", {31'd0, bus.wb_ack_o}, 32'd0);
            chk("dat_hold",      {16'd0, bus.wb_dat_o}, {16'd0, model_dat});
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        vec_t tbl [6];
        int   e0, a0, w;

        tbl[0] = '{16'h0042, 16'h1234, 1'b1, 2, 16'h5A5A, 1'b0, 1'b1, 1'b1, 16'h5A5A};
        tbl[1] = '{16'h0010, 16'h0000, 1'b0, 5, 16'hBEEF, 1'b0, 1'b0, 1'b1, 16'hBEEF};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 0, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0001};
        tbl[3] = '{16'h0000, 16'hA5A5, 1'b0, 1, 16'hC3C3, 1'b0, 1'b0, 1'b1, 16'hC3C3};
        tbl[4] = '{16'h1357, 16'h2468, 1'b1, 3, 16'h7777, 1'b1, 1'b1, 1'b0, 16'h7777};
        tbl[5] = '{16'h00AA, 16'h0055, 1'b0, 1, 16'h9999, 1'b0, 1'b0, 1'b1, 16'h9999};

        bus.wb_adr_i = 16'h0000; bus.wb_dat_i = 16'h0000; bus.wb_we_i = 1'b0;
        bus.wb_stb_i = 1'b0;     bus.wb_cyc_i = 1'b0;
        bus.drp_di   = 16'h0000; bus.drp_rdy  = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_drp_en",   {31'd0, bus.drp_en},   32'd0);
        chk("rst_drp_we",   {31'd0, bus.drp_we},   32'd0);
        chk("rst_drp_addr", {16'd0, bus.drp_addr}, 32'd0);
        chk("rst_drp_do",   {16'd0, bus.drp_do},   32'd0);
        chk("rst_wb_dat",   {16'd0, bus.wb_dat_o}, 32'd0);
        chk("rst_wb_ack",   {31'd0, bus.wb_ack_o}, 32'd0);
        chk("rst_wb_err",   {31'd0, bus.wb_err_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_txn(tbl[i], 0, 1'b0);

        // Back-to-back reads with stb held high through every ack.
        e0 = en_seen; a0 = ack_seen;
        for (int i = 0; i < 4; i++) begin
            run_txn(mk_vec(16'(i), 16'h0000, 1'b0, (i % 3) + 1, 16'h0100 + 16'(i), 1'b0),
                    (i == 0) ? 0 : 1, (i != 3));
        end
        chk("b2b_en_count",  en_seen - e0,  32'd4);
        chk("b2b_ack_count", ack_seen - a0, 32'd4);

        // Reset asserted while a DRP access is outstanding.
        bus.wb_adr_i = 16'h0ABC; bus.wb_dat_i = 16'h4321; bus.wb_we_i = 1'b1;
        bus.wb_stb_i = 1'b1;     bus.wb_cyc_i = 1'b1;
        @(negedge clk);
        chk("rst_pre_en", {31'd0, bus.drp_en}, 32'd1);
        en_exp++;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_drp_en",   {31'd0, bus.drp_en},   32'd0);
        chk("midrst_drp_we",   {31'd0, bus.drp_we},   32'd0);
        chk("midrst_drp_addr", {16'd0, bus.drp_addr}, 32'd0);
        chk("midrst_drp_do",   {16'd0, bus.drp_do},   32'd0);
        chk("midrst_wb_dat",   {16'd0, bus.wb_dat_o}, 32'd0);
        chk("midrst_wb_ack",   {31'd0, bus.wb_ack_o}, 32'd0);
        bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0;
        model_dat = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_dat", {16'd0, bus.wb_dat_o}, 32'd0);
        run_txn(mk_vec(16'h0321, 16'h8765, 1'b1, 2, 16'h1111, 1'b0), 0, 1'b0);

        // Random traffic against the transaction-level model.
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            chk("idle_dat_hold", {16'd0, bus.wb_dat_o}, {16'd0, model_dat});
            run_txn(mk_vec(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                           1'($urandom_range(0, 1)), $urandom_range(0, 6),
                           16'($urandom_range(0, 65535)), ($urandom_range(0, 3) == 0)),
                    0, 1'b0);
        end

`ifdef WB_DRP_TIMEOUT_EN
        // DRP never answers: err after TMO cycles, then a late rdy is ignored.
        bus.wb_adr_i = 16'h0077; bus.wb_dat_i = 16'h0000; bus.wb_we_i = 1'b0;
        bus.wb_stb_i = 1'b1;     bus.wb_cyc_i = 1'b1;
        @(negedge clk);
        chk("tmo_en", {31'd0, bus.drp_en}, 32'd1);
        en_exp++;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus.wb_err_o && w < 40);
        chk("tmo_latency", w, 32'(TMO));
        chk("tmo_err",     {31'd0, bus.wb_err_o}, 32'd1);
        chk("tmo_ack",     {31'd0, bus.wb_ack_o}, 32'd0);
        chk("tmo_dat",     {16'd0, bus.wb_dat_o}, 32'd0);
        model_dat = 16'h0000;
        bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0;
        bus.drp_rdy = 1'b1; bus.drp_di = 16'hDEAD;
        @(negedge clk);
        bus.drp_rdy = 1'b0;
        chk("tmo_err_one_cycle", {31'd0, bus.wb_err_o}, 32'd0);
        @(negedge clk);
        chk("late_rdy_no_ack", {31'd0, bus.wb_ack_o}, 32'd0);
        chk("late_rdy_no_dat", {16'd0, bus.wb_dat_o}, 32'd0);
        chk("late_rdy_no_en",  {31'd0, bus.drp_en},   32'd0);
`else
        // Without the watchdog a very slow DRP still completes normally.
        run_txn(mk_vec(16'h0BAD, 16'h0000, 1'b0, 2000, 16'hCAFE, 1'b0), 0, 1'b0);
`endif

        repeat (2) @(negedge clk);
        chk("en_total",  en_seen,  en_exp);
        chk("ack_total", ack_seen, ack_exp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
